// File: rtl/cmp_lut_pkg.sv
// cmp_lut_pkg: shared types and op legality for the comparator LUT loader (CMP_LUT_EQNE_EN enables eq/ne)
package cmp_lut_pkg;
  typedef enum logic [2:0] {OP_LT, OP_LE, OP_GT, OP_GE, OP_EQ, OP_NE} cmp_op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  function automatic logic op_legal(input logic [2:0] op);
`ifdef CMP_LUT_EQNE_EN
    return op <= 3'(OP_NE);
`else
    return op <= 3'(OP_GE);
`endif
  endfunction
endpackage

// File: rtl/cmp_lut_bit_eval.sv
// cmp_lut_bit_eval: one truth-table bit f(n) of the comparator (eq/ne only with CMP_LUT_EQNE_EN)
module cmp_lut_bit_eval
  import cmp_lut_pkg::*;
#(
  parameter int LUT_WIDTH = 4
) (
  input  logic [2:0]           i_op,
  input  logic                 i_swap,
  input  logic                 i_signed,
  input  logic [LUT_WIDTH-1:0] i_const,
  input  logic [LUT_WIDTH-1:0] i_n,
  output logic                 o_f
);
  logic signed [LUT_WIDTH:0] w_v, w_c, w_l, w_r;
  assign w_v = {i_signed & i_n[LUT_WIDTH-1], i_n};
  assign w_c = {i_signed & i_const[LUT_WIDTH-1], i_const};
  assign w_l = i_swap ? w_c : w_v;
  assign w_r = i_swap ? w_v : w_c;
  // compare one extra bit wide so signed and unsigned share one signed comparator
  always_comb begin
`ifdef CMP_LUT_EQNE_EN
    o_f = i_op == 3'(OP_LT) ? w_l <  w_r :
          i_op == 3'(OP_LE) ? w_l <= w_r :
          i_op == 3'(OP_GT) ? w_l >  w_r :
          i_op == 3'(OP_GE) ? w_l >= w_r :
          i_op == 3'(OP_EQ) ? w_l == w_r :
          i_op == 3'(OP_NE) ? w_l != w_r : 1'b0;
`else
    o_f = i_op == 3'(OP_LT) ? w_l <  w_r :
          i_op == 3'(OP_LE) ? w_l <= w_r :
          i_op == 3'(OP_GT) ? w_l >  w_r :
          i_op == 3'(OP_GE) ? w_l >= w_r : 1'b0;
`endif
  end
endmodule

// File: rtl/cmp_lut_cfg_loader.sv
// cmp_lut_cfg_loader: serial loader and shadow copy for a k-input comparator LUT (CMP_LUT_EQNE_EN enables eq/ne)
module cmp_lut_cfg_loader
  import cmp_lut_pkg::*;
#(
  parameter int LUT_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic [2:0]                i_cfg_op,
  input  logic                      i_cfg_swap,
  input  logic                      i_cfg_signed,
  input  logic [LUT_WIDTH-1:0]      i_cfg_const,
  output logic                      o_cfg_err,
  output logic                      o_lut_ce,
  output logic                      o_lut_di,
  output logic [(1<<LUT_WIDTH)-1:0] o_lut_init,
  output logic                      o_lut_valid,
  output logic                      o_done,
  input  logic [LUT_WIDTH-1:0]      i_q_a,
  output logic                      o_q_y
);
  localparam int N = 1 << LUT_WIDTH;
  localparam logic [LUT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LUT_WIDTH-1:0] CNT_ONE = 1;
  state_e r_state, w_next;
  logic [LUT_WIDTH-1:0] r_cnt, r_const;
  logic [2:0] r_op;
  logic r_swap, r_signed, r_ce, r_di, r_valid, r_done, r_err;
  logic [N-1:0] r_init;
  logic w_acc, w_legal, w_f;
  assign o_cfg_ready = r_state == S_IDLE;
  assign w_acc = i_cfg_valid & o_cfg_ready;
  assign w_legal = op_legal(i_cfg_op);
  cmp_lut_bit_eval #(.LUT_WIDTH(LUT_WIDTH)) u_eval (
    .i_op(r_op), .i_swap(r_swap), .i_signed(r_signed), .i_const(r_const), .i_n(r_cnt), .o_f(w_f)
  );
  // state register
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: legal accept starts a shift, last entry ends it, done lasts one cycle
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE  ? (w_acc && w_legal ? S_SHIFT : S_IDLE) :
             r_state == S_SHIFT ? (r_cnt == '0 ? S_DONE : S_SHIFT) : S_IDLE;
  end
  // datapath: latch request, stream truth table out msb-first into LUT and shadow
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_cnt    <= CNT_MAX;
      r_op     <= '0;
      r_swap   <= 1'b0;
      r_signed <= 1'b0;
      r_const  <= '0;
      r_ce     <= 1'b0;
      r_di     <= 1'b0;
      r_init   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err  <= w_acc & ~w_legal;
      r_done <= r_state == S_DONE;
      r_ce   <= r_state == S_SHIFT;
      r_di   <= r_state == S_SHIFT ? w_f : 1'b0;
      if (w_acc) begin
        r_op     <= i_cfg_op;
        r_swap   <= i_cfg_swap;
        r_signed <= i_cfg_signed;
        r_const  <= i_cfg_const;
      end
      if (w_acc && w_legal) begin
        r_cnt   <= CNT_MAX;
        r_valid <= 1'b0;
      end
      if (r_state == S_SHIFT) begin
        r_init <= {r_init[N-2:0], w_f};
        r_cnt  <= r_cnt - CNT_ONE;
      end
      if (r_state == S_DONE) r_valid <= 1'b1;
    end
  assign o_cfg_err   = r_err;
  assign o_lut_ce    = r_ce;
  assign o_lut_di    = r_di;
  assign o_lut_init  = r_init;
  assign o_lut_valid = r_valid;
  assign o_done      = r_done;
  assign o_q_y       = r_init[i_q_a] & r_valid;
endmodule

// File: tb/tb_cmp_lut_cfg_loader.sv
// tb_cmp_lut_cfg_loader: directed self-checking bench for cmp_lut_cfg_loader (LUT_WIDTH=4, either CMP_LUT_EQNE_EN build)
module tb_cmp_lut_cfg_loader;
  logic clk = 1'b0, arst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_swap = 1'b0, cfg_signed = 1'b0;
  logic [2:0] cfg_op = '0;
  logic [3:0] cfg_const = '0, q_a = '0;
  logic cfg_ready, cfg_err, lut_ce, lut_di, lut_valid, done, q_y;
  logic [15:0] lut_init;
  int tests = 0, fails = 0;

  cmp_lut_cfg_loader #(.LUT_WIDTH(4)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_op(cfg_op), .i_cfg_swap(cfg_swap), .i_cfg_signed(cfg_signed), .i_cfg_const(cfg_const),
    .o_cfg_err(cfg_err), .o_lut_ce(lut_ce), .o_lut_di(lut_di), .o_lut_init(lut_init),
    .o_lut_valid(lut_valid), .o_done(done), .i_q_a(q_a), .o_q_y(q_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input string tag, input logic [2:0] op, input logic sw, input logic sg,
                      input logic [3:0] c, input logic [15:0] exp_init);
    int ce_n, first_ce, done_at;
    logic [15:0] di_seq;
    ce_n = 0; first_ce = -1; done_at = -1; di_seq = '0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = op; cfg_swap = sw; cfg_signed = sg; cfg_const = c;
    #1 check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0; cfg_op = 3'd0; cfg_const = ~c; cfg_swap = ~sw;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (lut_ce) begin
        ce_n++;
        if (first_ce < 0) first_ce = i;
        di_seq = {di_seq[14:0], lut_di};
      end
      if (done) done_at = i;
    end
    check({tag, "_done_lat"}, 32'(done_at), 32'd17);
    check({tag, "_ce_cnt"}, 32'(ce_n), 32'd16);
    check({tag, "_first_ce"}, 32'(first_ce), 32'd1);
    check({tag, "_di_seq"}, 32'(di_seq), 32'(exp_init));
    check({tag, "_init"}, 32'(lut_init), 32'(exp_init));
    check({tag, "_valid"}, 32'(lut_valid), 32'd1);
    cfg_swap = 1'b0;
  endtask

  task automatic err_req(input string tag, input logic [2:0] op, input logic [15:0] keep_init);
    int ce_n;
    ce_n = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = op; cfg_const = 4'd9; cfg_swap = 1'b0; cfg_signed = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_err"}, 32'(cfg_err), 32'd1);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check({tag, "_err_pulse"}, 32'(cfg_err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (lut_ce) ce_n++;
      @(negedge clk);
    end
    check({tag, "_no_ce"}, 32'(ce_n), 32'd0);
    check({tag, "_init_kept"}, 32'(lut_init), 32'(keep_init));
    check({tag, "_valid_kept"}, 32'(lut_valid), 32'd1);
  endtask

  initial begin
    int rdy_low, d1, d2, ce_a, ce_b;
    logic [15:0] init_a;
    #12;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_outs", {26'd0, cfg_err, lut_ce, lut_di, lut_valid, done, q_y}, 32'd0);
    check("rst_init", 32'(lut_init), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    load("t1_lt5", 3'd0, 1'b0, 1'b0, 4'd5, 16'h001F);
    q_a = 4'd4; #1 check("t1_q4", 32'(q_y), 32'd1);
    q_a = 4'd5; #1 check("t1_q5", 32'(q_y), 32'd0);
    q_a = 4'd0; #1 check("t1_q0", 32'(q_y), 32'd1);

    load("t2_ge_sE", 3'd3, 1'b0, 1'b1, 4'hE, 16'hC0FF);
    q_a = 4'd13; #1 check("t2_q13", 32'(q_y), 32'd0);
    load("t2b_le_u7", 3'd1, 1'b0, 1'b0, 4'd7, 16'h00FF);
    load("t2c_gt_s1", 3'd2, 1'b0, 1'b1, 4'd1, 16'h00FC);
    load("t3_swlt5", 3'd0, 1'b1, 1'b0, 4'd5, 16'hFFC0);

    err_req("t5_op7", 3'd7, 16'hFFC0);
`ifdef CMP_LUT_EQNE_EN
    load("t5_eq9", 3'd4, 1'b0, 1'b0, 4'd9, 16'h0200);
    load("t5_ne9", 3'd5, 1'b0, 1'b0, 4'd9, 16'hFDFF);
`else
    err_req("t5_eq9", 3'd4, 16'hFFC0);
    err_req("t5_ne9", 3'd5, 16'hFFC0);
`endif

    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = 3'd0; cfg_swap = 1'b0; cfg_signed = 1'b0; cfg_const = 4'd5;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_op = 3'd3; cfg_const = 4'hE; cfg_signed = 1'b1;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("t4_rst_init", 32'(lut_init), 32'd0);
    check("t4_rst_outs", {27'd0, cfg_err, lut_ce, lut_di, lut_valid, done}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("t4_ready", 32'(cfg_ready), 32'd1);
    check("t4_valid", 32'(lut_valid), 32'd0);
    q_a = 4'd2; #1 check("t4_qy", 32'(q_y), 32'd0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("t4_no_ce", 32'(lut_ce), 32'd0);

    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = 3'd0; cfg_swap = 1'b0; cfg_signed = 1'b0; cfg_const = 4'd5;
    @(negedge clk);
    cfg_op = 3'd3; cfg_signed = 1'b1; cfg_const = 4'hE;
    rdy_low = cfg_ready ? 0 : 1; d1 = -1; d2 = -1; ce_a = 0; ce_b = 0; init_a = '0;
    for (int i = 1; i <= 60 && d2 < 0; i++) begin
      @(negedge clk);
      if (d1 < 0 && !cfg_ready) rdy_low++;
      if (lut_ce) begin
        if (d1 < 0) ce_a++;
        else ce_b++;
      end
      if (done && d1 < 0) begin
        d1 = i;
        init_a = lut_init;
      end else if (done) d2 = i;
      if (i == 18) cfg_valid = 1'b0;
    end
    check("t6_ready_low", 32'(rdy_low), 32'd17);
    check("t6_done1", 32'(d1), 32'd17);
    check("t6_done2", 32'(d2), 32'd35);
    check("t6_ce_a", 32'(ce_a), 32'd16);
    check("t6_ce_b", 32'(ce_b), 32'd16);
    check("t6_init_a", 32'(init_a), 32'h001F);
    check("t6_init_b", 32'(lut_init), 32'hC0FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
